// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions (gfedcba, active-low) used by both the encoder and the scan-capture path.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;

  function automatic seg_dec_t seg_decode(input seg_t seg);
    seg_dec_t r;
    r = '0;
    if (seg == SEG_BLANK) r.blank = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        r.valid  = 1'b1;
        r.nibble = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_scan_capture_if.sv
// Captured-frame port: DIGITS nibbles plus per-digit blank/error flags on a valid/ready handshake.
interface sevenseg_scan_capture_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] out_data;
  logic [DIGITS-1:0]   out_blank;
  logic [DIGITS-1:0]   out_err;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_data, out_blank, out_err, out_valid, input out_ready);
  modport slave  (input out_data, out_blank, out_err, out_valid, output out_ready);
endinterface

// File: rtl/sevenseg_scan_capture_seg_hex_decoder.sv
// Combinational segment-pattern to hex nibble decode; anything neither hex nor blank is flagged as error.
module seg_hex_decoder
  import sevenseg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  seg_dec_t dec;

  assign dec      = seg_decode(seg_i);
  assign nibble_o = dec.nibble;
  assign blank_o  = dec.blank;
  assign err_o    = !dec.valid && !dec.blank;

endmodule

// File: rtl/sevenseg_scan_capture.sv
// Samples a multiplexed 7-seg bus, rebuilds a DIGITS-nibble frame; slot write STABLE_CYCLES+2 cycles after input settles.
// Frame held while out_valid && !out_ready; a frame completing then is dropped and flagged with an overrun pulse.
module sevenseg_scan_capture
  import sevenseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  seg_t                           seg_n,
  input  logic [DIGITS-1:0]              an_n,
  sevenseg_scan_capture_if.master        out,
  output logic                           overrun
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

  seg_t seg_s1_q, seg_s2_q, prev_seg_q;
  logic [DIGITS-1:0] an_s1_q, an_s2_q;
  logic [IW-1:0] idx, prev_idx_q;
  logic prev_addr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0] seen_q, seen_d, wr_mask;
  logic [4*DIGITS-1:0] slot_data_q, slot_data_d, data_q;
  logic [DIGITS-1:0] slot_blank_q, slot_blank_d, slot_err_q, slot_err_d, blank_q, err_q;
  out_state_e state_q, state_d;
  logic overrun_q, overrun_d, load;
  logic [DIGITS-1:0] an_low;
  logic addr, same, wr, complete, hs;
  logic [3:0] dec_nib;
  logic dec_blank, dec_err;

  seg_hex_decoder u_dec (
    .seg_i    (seg_s2_q),
    .nibble_o (dec_nib),
    .blank_o  (dec_blank),
    .err_o    (dec_err)
  );

  // Addressed only when exactly one anode is active.
  assign an_low = ~an_s2_q;
  assign addr   = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (an_low[k]) idx = IW'(k);
    end
  end

  assign same     = addr && prev_addr_q && (idx == prev_idx_q) && (seg_s2_q == prev_seg_q);
  assign wr       = same && (cnt_q == CNT_ARM);
  assign wr_mask  = wr ? (DIGITS'(1) << idx) : '0;
  assign complete = &seen_q;
  assign hs       = (state_q == ST_FULL) && out.out_ready;

  always_comb begin
    cnt_d        = '0;
    slot_data_d  = slot_data_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (wr_mask[k]) begin
        slot_data_d[4*k +: 4] = (dec_blank || dec_err) ? 4'h0 : dec_nib;
        slot_blank_d[k]       = dec_blank;
        slot_err_d[k]         = dec_err;
      end
    end
    seen_d = (complete ? '0 : seen_q) | wr_mask;
  end

  always_comb begin
    state_d   = state_q;
    load      = complete && ((state_q == ST_EMPTY) || hs);
    overrun_d = complete && !load;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (!load && hs) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q     <= SEG_BLANK;
      seg_s2_q     <= SEG_BLANK;
      an_s1_q      <= '1;
      an_s2_q      <= '1;
      prev_seg_q   <= SEG_BLANK;
      prev_idx_q   <= '0;
      prev_addr_q  <= 1'b0;
      cnt_q        <= '0;
      seen_q       <= '0;
      slot_data_q  <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      data_q       <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      state_q      <= ST_EMPTY;
      overrun_q    <= 1'b0;
    end else begin
      seg_s1_q     <= seg_n;
      seg_s2_q     <= seg_s1_q;
      an_s1_q      <= an_n;
      an_s2_q      <= an_s1_q;
      prev_seg_q   <= seg_s2_q;
      prev_idx_q   <= idx;
      prev_addr_q  <= addr;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      slot_data_q  <= slot_data_d;
      slot_blank_q <= slot_blank_d;
      slot_err_q   <= slot_err_d;
      state_q      <= state_d;
      overrun_q    <= overrun_d;
      if (load) begin
        data_q  <= slot_data_q;
        blank_q <= slot_blank_q;
        err_q   <= slot_err_q;
      end
    end
  end

  assign out.out_data  = data_q;
  assign out.out_blank = blank_q;
  assign out.out_err   = err_q;
  assign out.out_valid = (state_q == ST_FULL);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Scoreboard bench for sevenseg_scan_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_sevenseg_scan_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_n = 7'b1111111;
  logic [3:0] an_n = 4'b1111;
  logic       overrun;

  sevenseg_scan_capture_if #(.DIGITS(4)) out_if ();

  sevenseg_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .out     (out_if.master),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int n_chk = 0;
  int n_fail = 0;
  int ovr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scan_digit(input int k, input logic [6:0] seg, input int hold);
    logic [3:0] a;
    a = 4'b1111;
    a[k] = 1'b0;
    an_n = a;
    seg_n = seg;
    repeat (hold) step();
    an_n = 4'b1111;
    step();
  endtask

  task automatic scan_frame(input logic [15:0] word, input int hold);
    for (int k = 0; k < 4; k++) scan_digit(k, CODES[word[4*k +: 4]], hold);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
    exp_t x;
    x.d = d; x.b = b; x.e = e;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      step();
      i++;
    end
    chk("drain", 32'(sb.size()), 0);
  endtask

  // Frames are popped and compared at every accepted handshake.
  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
      chk("frame_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("frame_data", 32'(out_if.out_data), 32'(got.d));
        chk("frame_blank", 32'(out_if.out_blank), 32'(got.b));
        chk("frame_err", 32'(out_if.out_err), 32'(got.e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    int mx;
    out_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(out_if.out_valid), 0);
    chk("rst_data", 32'(out_if.out_data), 0);
    chk("rst_blank", 32'(out_if.out_blank), 0);
    chk("rst_err", 32'(out_if.out_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step();

    push(16'hF0A3, 4'h0, 4'h0);
    scan_frame(16'hF0A3, 8);
    wait_drain(40);
    step(); step();
    chk("valid_drop", 32'(out_if.out_valid), 0);

    scan_frame(16'h4321, 3);
    repeat (10) step();
    chk("short_no_frame", 32'(out_if.out_valid), 0);
    chk("short_seen", 32'(dut.seen_q), 0);
    push(16'h4321, 4'h0, 4'h0);
    scan_frame(16'h4321, 4);
    wait_drain(40);

    push(16'h7065, 4'h0, 4'b0100);
    scan_digit(0, CODES[5], 8);
    scan_digit(1, CODES[6], 8);
    scan_digit(2, 7'b1111110, 8);
    scan_digit(3, CODES[7], 8);
    wait_drain(40);

    push(16'hB098, 4'b0100, 4'h0);
    scan_digit(0, CODES[8], 8);
    scan_digit(1, CODES[9], 8);
    scan_digit(2, 7'b1111111, 8);
    scan_digit(3, CODES[11], 8);
    wait_drain(40);

    out_if.out_ready = 1'b0;
    push(16'hFEDC, 4'h0, 4'h0);
    scan_frame(16'hFEDC, 8);
    i = 0;
    while (out_if.out_valid !== 1'b1 && i < 40) begin
      step();
      i++;
    end
    chk("held_valid", 32'(out_if.out_valid), 1);
    chk("held_data", 32'(out_if.out_data), 32'h0000FEDC);
    scan_frame(16'h1111, 8);
    repeat (10) step();
    chk("held_data_after", 32'(out_if.out_data), 32'h0000FEDC);
    chk("held_valid_after", 32'(out_if.out_valid), 1);
    chk("overrun_once", 32'(ovr_cnt), 1);
    out_if.out_ready = 1'b1;
    wait_drain(20);
    step(); step();
    chk("valid_after_hs", 32'(out_if.out_valid), 0);

    mx = 0;
    an_n = 4'b1100;
    seg_n = CODES[5];
    repeat (10) begin
      step();
      if (int'(dut.cnt_q) > mx) mx = int'(dut.cnt_q);
    end
    chk("cnt_two_low", 32'(mx), 0);
    an_n = 4'b1111;
    repeat (10) begin
      step();
      if (int'(dut.cnt_q) > mx) mx = int'(dut.cnt_q);
    end
    chk("cnt_none_low", 32'(mx), 0);
    chk("unaddr_seen", 32'(dut.seen_q), 0);

    scan_digit(0, CODES[6], 8);
    scan_digit(1, CODES[7], 8);
    repeat (3) step();
    chk("pre_rst_seen", 32'(dut.seen_q), 32'h3);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_if.out_valid), 0);
    chk("mid_rst_data", 32'(out_if.out_data), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_seen", 32'(dut.seen_q), 0);
    rst = 1'b0;
    step();
    scan_digit(2, CODES[8], 8);
    scan_digit(3, CODES[9], 8);
    repeat (10) step();
    chk("post_rst_no_frame", 32'(out_if.out_valid), 0);
    push(16'h9876, 4'h0, 4'h0);
    scan_digit(0, CODES[6], 8);
    scan_digit(1, CODES[7], 8);
    wait_drain(40);

    chk("overrun_total", 32'(ovr_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
